// File: rtl/cam_download_arbiter_pkg.sv
// Shared definitions for the camera download arbiter.
// Contents:
//   state_e         - arbiter FSM states
//   MAX_LEVEL       - highest meaningful buffer fill step (10 = 100%)
//   GRANT_*         - one-hot link owner encodings
//   level_to_bytes  - converts a 0..10 fill level into a byte count
package cam_download_arbiter_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_FETCH,
      S_CAPTURE,
      S_LOAD,
      S_WAIT_TX,
      S_DONE
   } state_e;

   localparam logic [3:0] MAX_LEVEL  = 4'd10;

   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_CAM1 = 2'b01;
   localparam logic [1:0] GRANT_CAM2 = 2'b10;

   // Levels above 10 are clamped, so the result stays within 8 bits for
   // any bytes_per_pct up to 25.
   function automatic logic [7:0] level_to_bytes(input logic [3:0] level,
                                                 input int unsigned bytes_per_pct);
      logic [3:0] clamped;
      clamped = (level > MAX_LEVEL) ? MAX_LEVEL : level;
      return 8'(32'(clamped) * bytes_per_pct);
   endfunction

endpackage

// File: rtl/cam_download_arbiter_if.sv
// Bundle of all signals between the arbiter, the two camera buffers,
// the serializer and the host.
//   master modport : the arbiter
//   slave modport  : the camera buffers / serializer / host side
// Signals:
//   req1/req2          camera ready-to-download requests
//   level1/level2      buffer fill level, 0..10
//   rd_data1/rd_data2  current byte of each buffer
//   rd_strobe1/2       pop one byte from the buffer
//   tx_data/tx_load    byte and load strobe to the serializer
//   tx_empty           serializer has shifted out its byte
//   abort              host abort of the current transfer
//   grant              one-hot link owner
//   busy               transfer in progress
//   done1/done2        download-complete pulses
//   err                sticky serializer timeout flag
interface cam_download_arbiter_if;

   logic       req1;
   logic       req2;
   logic [3:0] level1;
   logic [3:0] level2;
   logic [7:0] rd_data1;
   logic [7:0] rd_data2;
   logic       rd_strobe1;
   logic       rd_strobe2;
   logic [7:0] tx_data;
   logic       tx_load;
   logic       tx_empty;
   logic       abort;
   logic [1:0] grant;
   logic       busy;
   logic       done1;
   logic       done2;
   logic       err;

   modport master (
      input  req1, req2, level1, level2, rd_data1, rd_data2, tx_empty, abort,
      output rd_strobe1, rd_strobe2, tx_data, tx_load, grant, busy,
             done1, done2, err
   );

   modport slave (
      output req1, req2, level1, level2, rd_data1, rd_data2, tx_empty, abort,
      input  rd_strobe1, rd_strobe2, tx_data, tx_load, grant, busy,
             done1, done2, err
   );

endinterface

// File: rtl/cam_download_arbiter_cycle_timer.sv
// Loadable down-counter with an expire flag.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   load_i         reload the counter with load_val_i (wins over en_i)
//   load_val_i     reload value
//   en_i           count down by one per cycle, stopping at zero
//   expired_o      counter is at zero
module cycle_timer #(
   parameter int unsigned W = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   output logic         expired_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (en_i && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired_o = (count_q == '0);

endmodule

// File: rtl/cam_download_arbiter.sv
// Round-robin arbiter sharing one serial download link between two camera
// buffers. The winning camera's buffer is drained byte by byte into the
// serializer (load held LOAD_HOLD cycles, then wait for tx_empty), after
// which the link is released and priority passes to the other camera.
// Ports:
//   clock  camera-domain clock
//   reset  asynchronous active-low reset
//   bus    arbiter side (master modport) of cam_download_arbiter_if
// Parameters:
//   BYTES_PER_PCT  bytes per 10% buffer step
//   LOAD_HOLD      cycles tx_load is held per byte
//   TX_TIMEOUT     cycles to wait for tx_empty before flagging err
module cam_download_arbiter
   import cam_download_arbiter_pkg::*;
#(
   parameter int unsigned BYTES_PER_PCT = 4,
   parameter int unsigned LOAD_HOLD     = 16,
   parameter int unsigned TX_TIMEOUT    = 1023
) (
   input  logic                   clock,
   input  logic                   reset,
   cam_download_arbiter_if.master bus
);

   localparam int unsigned HOLD_W = $clog2(LOAD_HOLD + 1);
   localparam int unsigned TMO_W  = $clog2(TX_TIMEOUT + 1);
   // Counters are reloaded with N-1 so that expiry lands on the N-th cycle.
   localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(LOAD_HOLD - 1);
   localparam logic [TMO_W-1:0]  TMO_RELOAD  = TMO_W'(TX_TIMEOUT - 1);

   state_e     state_q;
   logic [1:0] grant_q;
   logic       busy_q;
   logic       tx_load_q;
   logic [7:0] tx_data_q;
   logic [1:0] rd_strobe_q;
   logic [1:0] done_q;
   logic       err_q;
   logic       ptr_q;        // 0: cam1 has priority, 1: cam2
   logic       owner_q;      // 0: cam1 owns the link, 1: cam2
   logic [7:0] remaining_q;

   logic       hold_expired;
   logic       tmo_expired;
   logic       winner;
   logic [1:0] owner_mask;
   logic [7:0] grant_bytes;

   // Both timers sit loaded while outside their state, so each entry
   // starts a fresh count.
   cycle_timer #(.W(HOLD_W)) u_hold_timer (
      .clk_i      (clock),
      .rst_ni     (reset),
      .load_i     (state_q != S_LOAD),
      .load_val_i (HOLD_RELOAD),
      .en_i       (state_q == S_LOAD),
      .expired_o  (hold_expired)
   );

   cycle_timer #(.W(TMO_W)) u_tmo_timer (
      .clk_i      (clock),
      .rst_ni     (reset),
      .load_i     (state_q != S_WAIT_TX),
      .load_val_i (TMO_RELOAD),
      .en_i       (state_q == S_WAIT_TX),
      .expired_o  (tmo_expired)
   );

   // With both requests pending the pointer decides; otherwise the lone
   // requester wins.
   assign winner      = (bus.req1 && bus.req2) ? ptr_q : bus.req2;
   assign owner_mask  = owner_q ? GRANT_CAM2 : GRANT_CAM1;
   assign grant_bytes = level_to_bytes(owner_q ? bus.level2 : bus.level1, BYTES_PER_PCT);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         grant_q     <= GRANT_NONE;
         busy_q      <= 1'b0;
         tx_load_q   <= 1'b0;
         tx_data_q   <= 8'h00;
         rd_strobe_q <= 2'b00;
         done_q      <= 2'b00;
         err_q       <= 1'b0;
         ptr_q       <= 1'b0;
         owner_q     <= 1'b0;
         remaining_q <= 8'd0;
      end else begin
         rd_strobe_q <= 2'b00;
         done_q      <= 2'b00;
         if (bus.abort && (state_q != S_IDLE)) begin
            // Abort beats everything, including a simultaneous timeout.
            state_q   <= S_IDLE;
            grant_q   <= GRANT_NONE;
            busy_q    <= 1'b0;
            tx_load_q <= 1'b0;
            ptr_q     <= ~owner_q;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (bus.req1 || bus.req2) begin
                     owner_q <= winner;
                     grant_q <= winner ? GRANT_CAM2 : GRANT_CAM1;
                     busy_q  <= 1'b1;
                     state_q <= S_GRANT;
                  end
               end
               S_GRANT: begin
                  remaining_q <= grant_bytes;
                  if (grant_bytes == 8'd0) begin
                     done_q  <= owner_mask;
                     grant_q <= GRANT_NONE;
                     busy_q  <= 1'b0;
                     state_q <= S_DONE;
                  end else begin
                     rd_strobe_q <= owner_mask;
                     state_q     <= S_FETCH;
                  end
               end
               S_FETCH: begin
                  state_q <= S_CAPTURE;
               end
               S_CAPTURE: begin
                  // The buffer presents the popped byte one cycle after the strobe.
                  tx_data_q <= owner_q ? bus.rd_data2 : bus.rd_data1;
                  tx_load_q <= 1'b1;
                  state_q   <= S_LOAD;
               end
               S_LOAD: begin
                  if (hold_expired) begin
                     tx_load_q <= 1'b0;
                     state_q   <= S_WAIT_TX;
                  end
               end
               S_WAIT_TX: begin
                  if (bus.tx_empty) begin
                     remaining_q <= remaining_q - 8'd1;
                     if (remaining_q == 8'd1) begin
                        done_q  <= owner_mask;
                        grant_q <= GRANT_NONE;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                     end else begin
                        rd_strobe_q <= owner_mask;
                        state_q     <= S_FETCH;
                     end
                  end else if (tmo_expired) begin
                     // Serializer never came back: abandon, and rotate so the
                     // other camera is not starved by a stuck transfer.
                     err_q   <= 1'b1;
                     grant_q <= GRANT_NONE;
                     busy_q  <= 1'b0;
                     ptr_q   <= ~owner_q;
                     state_q <= S_IDLE;
                  end
               end
               S_DONE: begin
                  ptr_q   <= ~owner_q;
                  state_q <= S_IDLE;
               end
               default: begin
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

   // Strobes and pulses are cut in the abort cycle itself, not a cycle later.
   assign bus.tx_load    = tx_load_q & ~bus.abort;
   assign bus.rd_strobe1 = rd_strobe_q[0] & ~bus.abort;
   assign bus.rd_strobe2 = rd_strobe_q[1] & ~bus.abort;
   assign bus.done1      = done_q[0] & ~bus.abort;
   assign bus.done2      = done_q[1] & ~bus.abort;
   assign bus.tx_data    = tx_data_q;
   assign bus.grant      = grant_q;
   assign bus.busy       = busy_q;
   assign bus.err        = err_q;

endmodule

// File: tb/tb_cam_download_arbiter.sv
module tb_cam_download_arbiter;

   localparam int LOAD_HOLD = 16;
   localparam int TX_LAT    = 3;                    // serializer busy cycles after load drops
   localparam int BYTE_CYC  = 2 + LOAD_HOLD + TX_LAT; // FETCH + CAPTURE + LOAD + WAIT_TX

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   cam_download_arbiter_if bus();

   cam_download_arbiter #(
      .BYTES_PER_PCT (4),
      .LOAD_HOLD     (LOAD_HOLD),
      .TX_TIMEOUT    (1023)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   function automatic logic [7:0] pat(input logic cam, input int idx);
      return cam ? 8'(8'h50 + 3 * idx) : 8'(8'hA0 + idx);
   endfunction

   // Camera buffer model: a strobe pops the next pattern byte, visible next cycle.
   logic [7:0] rd1  = 8'h00;
   logic [7:0] rd2  = 8'h00;
   int         pop1 = 0;
   int         pop2 = 0;
   always @(posedge clock) begin
      if (bus.rd_strobe1) begin
         rd1  <= pat(1'b0, pop1);
         pop1 <= pop1 + 1;
      end
      if (bus.rd_strobe2) begin
         rd2  <= pat(1'b1, pop2);
         pop2 <= pop2 + 1;
      end
   end
   assign bus.rd_data1 = rd1;
   assign bus.rd_data2 = rd2;

   // Serializer model: empty drops on load, returns TX_LAT cycles after load ends.
   logic stall      = 1'b0;
   logic tx_empty_m = 1'b1;
   int   ecnt       = 0;
   always @(negedge clock) begin
      if (bus.tx_load) begin
         tx_empty_m <= 1'b0;
         ecnt       <= TX_LAT;
      end else if (!stall && ecnt > 0) begin
         ecnt <= ecnt - 1;
         if (ecnt == 1) tx_empty_m <= 1'b1;
      end
   end
   assign bus.tx_empty = tx_empty_m;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   // One complete transfer: request, check grant, follow every byte, check done.
   task automatic run_xfer(input logic r1, input logic r2, input logic [3:0] l1,
                           input logic [3:0] l2, input logic [1:0] eg, input int eb);
      int p1, p2, lat, nl, w;
      logic prev;
      p1 = pop1;
      p2 = pop2;
      bus.req1 = r1;
      bus.req2 = r2;
      bus.level1 = l1;
      bus.level2 = l2;
      tick;
      chk("grant", 32'(bus.grant), 32'(eg));
      chk("busy_in_grant", 32'(bus.busy), 32'd1);
      // Requests dropped right after the grant must not shorten the transfer.
      bus.req1 = 1'b0;
      bus.req2 = 1'b0;
      lat = 0; nl = 0; w = 0; prev = 1'b0;
      while (!(bus.done1 || bus.done2) && lat < 2000) begin
         tick;
         lat++;
         if (bus.rd_strobe1 || bus.rd_strobe2)
            chk("strobe_owner", 32'({bus.rd_strobe2, bus.rd_strobe1}), 32'(eg));
         if (bus.tx_load) begin
            if (!prev) begin
               chk("tx_data", 32'(bus.tx_data),
                   32'(pat(eg[1], (eg[1] ? pop2 : pop1) - 1)));
               nl++;
               w = 0;
            end
            w++;
         end else if (prev) begin
            chk("load_width", w, LOAD_HOLD);
         end
         prev = bus.tx_load;
      end
      chk("done_latency", lat, 1 + BYTE_CYC * eb);
      chk("done_owner", 32'({bus.done2, bus.done1}), 32'(eg));
      chk("grant_in_done", 32'(bus.grant), 32'd0);
      chk("busy_in_done", 32'(bus.busy), 32'd0);
      tick;
      chk("done_pulse_end", 32'(bus.done1 | bus.done2), 32'd0);
      chk("loads", nl, eb);
      chk("pops1", pop1 - p1, eg[0] ? eb : 0);
      chk("pops2", pop2 - p2, eg[1] ? eb : 0);
   endtask

   typedef struct {
      logic       r1;
      logic       r2;
      logic [3:0] l1;
      logic [3:0] l2;
      logic [1:0] eg;
      int         eb;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int   lat, nl, dn, p1;
      logic prev;

      // {req1, req2, level1, level2, expected grant, expected bytes}
      vecs[0] = '{1'b1, 1'b1, 4'd1,  4'd1,  2'b01, 4};   // contention from reset: cam1
      vecs[1] = '{1'b1, 1'b1, 4'd1,  4'd1,  2'b10, 4};   // pointer moved: cam2
      vecs[2] = '{1'b0, 1'b1, 4'd1,  4'd0,  2'b10, 0};   // zero level
      vecs[3] = '{1'b1, 1'b0, 4'd2,  4'd0,  2'b01, 8};   // single request
      vecs[4] = '{1'b1, 1'b0, 4'd15, 4'd0,  2'b01, 40};  // clamp 15 -> 10
      vecs[5] = '{1'b1, 1'b1, 4'd3,  4'd10, 2'b10, 40};  // contention, pointer at cam2
      vecs[6] = '{1'b0, 1'b1, 4'd0,  4'd11, 2'b10, 40};  // clamp 11 -> 10

      bus.req1 = 1'b0;
      bus.req2 = 1'b0;
      bus.level1 = 4'd0;
      bus.level2 = 4'd0;
      bus.abort = 1'b0;

      repeat (3) tick;
      chk("rst_grant", 32'(bus.grant), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_tx_load", 32'(bus.tx_load), 32'd0);
      chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
      chk("rst_strobes", 32'({bus.rd_strobe2, bus.rd_strobe1}), 32'd0);
      chk("rst_done", 32'({bus.done2, bus.done1}), 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
      reset = 1'b1;
      repeat (2) tick;

      for (int i = 0; i < 7; i++)
         run_xfer(vecs[i].r1, vecs[i].r2, vecs[i].l1, vecs[i].l2, vecs[i].eg, vecs[i].eb);

      // Abort in the middle of the third byte's load; pointer is at cam1 here.
      p1 = pop1;
      bus.req1 = 1'b1;
      bus.level1 = 4'd2;
      tick;
      chk("abort_grant", 32'(bus.grant), 32'b01);
      bus.req1 = 1'b0;
      nl = 0; lat = 0; prev = 1'b0; dn = 0;
      while (nl < 3 && lat < 500) begin
         tick;
         lat++;
         if (bus.tx_load && !prev) nl++;
         prev = bus.tx_load;
      end
      chk("abort_reach_byte3", nl, 3);
      repeat (5) tick;
      chk("abort_pre_load", 32'(bus.tx_load), 32'd1);
      bus.abort = 1'b1;
      #1;
      chk("abort_load_gated", 32'(bus.tx_load), 32'd0);
      tick;
      bus.abort = 1'b0;
      chk("abort_idle_grant", 32'(bus.grant), 32'd0);
      chk("abort_idle_busy", 32'(bus.busy), 32'd0);
      for (int k = 0; k < 5; k++) begin
         if (bus.done1 || bus.done2 || bus.grant != 2'b00) dn++;
         tick;
      end
      chk("abort_stays_idle", dn, 0);
      chk("abort_pops", pop1 - p1, 3);
      run_xfer(1'b1, 1'b1, 4'd1, 4'd1, 2'b10, 4);   // abort handed priority to cam2

      // Serializer never returns empty: timeout after 1023 WAIT_TX cycles.
      stall = 1'b1;
      bus.req1 = 1'b1;
      bus.level1 = 4'd1;
      tick;
      chk("tmo_grant", 32'(bus.grant), 32'b01);
      bus.req1 = 1'b0;
      lat = 0; dn = 0;
      while (!bus.err && lat < 2000) begin
         tick;
         lat++;
         if (bus.done1 || bus.done2) dn++;
      end
      chk("tmo_latency", lat, 2 + LOAD_HOLD + 1023 + 1);
      chk("tmo_err", 32'(bus.err), 32'd1);
      chk("tmo_grant_clear", 32'(bus.grant), 32'd0);
      chk("tmo_busy_clear", 32'(bus.busy), 32'd0);
      chk("tmo_no_done", dn, 0);
      stall = 1'b0;
      repeat (6) tick;
      run_xfer(1'b0, 1'b1, 4'd0, 4'd1, 2'b10, 4);
      chk("err_sticky", 32'(bus.err), 32'd1);

      reset = 1'b0;
      #1;
      chk("err_reset", 32'(bus.err), 32'd0);
      chk("grant_reset", 32'(bus.grant), 32'd0);
      tick;
      reset = 1'b1;
      tick;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cam_download_arbiter.md
Name: cam_download_arbiter

Overview:
- Shares the single serial download link (byte loader, serializer with load/empty handshake) between camera 1 and camera 2 buffers.
- Grants the link round-robin to a camera reporting ready-to-download.
- Drains that camera's buffer byte by byte (count derived from its 0–10 fill level), then releases the link.
- Sits between the two camera/buffer instances and the serializer, on the divided camera clock.

Parameters:
- BYTES_PER_PCT, 4: bytes per 10% buffer step.
- LOAD_HOLD, 16: cycles tx_load is held per byte; matches the serializer's 16x slower shift clock.
- TX_TIMEOUT, 1023: maximum cycles to wait for tx_empty after a load before flagging an error.

Ports:
- clock  in  1  camera-domain clock.
- reset  in  1  asynchronous, active-low reset.
- req1  in  1  camera 1 ready to download (idle display).
- req2  in  1  camera 2 ready to download.
- level1  in  4  camera 1 buffer fill, 0..10.
- level2  in  4  camera 2 buffer fill, 0..10.
- rd_data1  in  8  camera 1 buffer current byte.
- rd_data2  in  8  camera 2 buffer current byte.
- rd_strobe1  out  1  pop one byte from camera 1 buffer (1-cycle pulse).
- rd_strobe2  out  1  pop one byte from camera 2 buffer (1-cycle pulse).
- tx_data  out  8  byte to serializer.
- tx_load  out  1  serializer load.
- tx_empty  in  1  serializer idle/shifted out.
- abort  in  1  host abort of current transfer.
- grant  out  2  one-hot link owner: 01 = cam1, 10 = cam2, 00 = none.
- busy  out  1  transfer in progress.
- done1  out  1  1-cycle pulse when camera 1 download completes.
- done2  out  1  1-cycle pulse when camera 2 download completes.
- err  out  1  sticky tx timeout flag.

Behaviour:
- Reset (asynchronous, active-low): state IDLE, grant=00, busy=0, tx_load=0, tx_data=0x00, rd_strobe*=0, done*=0, err=0, priority pointer = cam1.
- States: IDLE, GRANT, FETCH, CAPTURE, LOAD, WAIT_TX, DONE.
- IDLE: arbitrate among asserted req1/req2.
  - One request: that camera wins.
  - Both requests: the priority pointer's camera wins.
  - Winner goes to GRANT next cycle.
- GRANT (1 cycle):
  - grant and busy asserted.
  - remaining = min(level,10) × BYTES_PER_PCT, latched in an 8-bit register.
  - remaining == 0 → DONE; else → FETCH.
- FETCH (1 cycle): the owner's rd_strobe pulses high → CAPTURE.
- CAPTURE (1 cycle): tx_data ← owner's rd_data (valid the cycle after the strobe) → LOAD.
- LOAD: tx_load=1 for exactly LOAD_HOLD cycles, tx_data stable → WAIT_TX.
- WAIT_TX: wait for tx_empty=1.
  - On tx_empty=1, remaining decrements. If the new value is 0 → DONE; else → FETCH.
  - Timeout counter runs in WAIT_TX only and clears on state entry.
  - Counter reaches TX_TIMEOUT → err=1 (sticky until reset), transfer abandoned → IDLE, no done pulse.
- DONE (1 cycle):
  - Owner's done pulse = 1, grant → 00, busy → 0.
  - Priority pointer → the other camera → IDLE.
- Request lifetime: req is sampled only in IDLE. Deassertion mid-transfer has no effect; remaining stays latched.
- abort:
  - In any non-IDLE state, the next state is IDLE.
  - tx_load and rd_strobe* drop in that cycle (combinational gating); no done pulse.
  - Priority pointer toggles to the other camera.
  - In IDLE, abort has no effect.
- Simultaneous abort and timeout in the same cycle: abort wins; err is not set.
- Level > 10 is clamped to 10, so maximum remaining = 40 at default and never overflows 8 bits.
- At most one rd_strobe pulses per byte. rd_strobe1 and rd_strobe2 are never high together.
- Throughput per byte: 1 (FETCH) + 1 (CAPTURE) + LOAD_HOLD + WAIT_TX duration.

Decomposition:
- Shared package:
  - state enum.
  - MAX_LEVEL=10.
  - GRANT_NONE/GRANT_CAM1/GRANT_CAM2 encodings.
  - level-to-byte-count function.
- Sub-module cycle_timer: loadable down-counter with an expire flag.
  - Instance 1: LOAD_HOLD.
  - Instance 2: TX_TIMEOUT.

Test Plan:
- Single request: req1=1, level1=2, tx_empty returns 3 cycles after each load drop → 8 rd_strobe1 pulses, tx_data sequence equals the rd_data1 sequence, each tx_load 16 cycles wide, one done1 pulse, grant 01→00.
- Contention: req1=req2=1 from reset, levels 1 and 1 → cam1 served first (4 bytes, done1), then cam2 (4 bytes, done2); repeat both → cam2 served first.
- Zero level: req2=1, level2=0 → GRANT→DONE in 2 cycles, done2 pulse, no rd_strobe2, no tx_load.
- Clamp and deassertion: level1=15, req1 drops after GRANT → exactly 40 bytes transferred, done1 pulses.
- Abort: abort mid-LOAD on byte 3 → tx_load low the same cycle, IDLE next cycle, no done1, next contention won by cam2.
- Timeout: tx_empty held 0 for TX_TIMEOUT=1023 cycles → err=1, grant=00; err stays 1 across later transfers and clears only on reset=0.
